// File: rtl/fu_branch_pipe.sv
// Registered branch/jump execution unit: resolves RV32 branches, JAL and JALR,
// produces the link value and the mispredict flag, with age-based flush of in-flight work.
module fu_branch_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned TAG_W     = $clog2(ROB_DEPTH),
  parameter int unsigned PREG_W    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_func3,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [PREG_W-1:0] in_pd,
  input  logic [TAG_W-1:0]  in_rob_tag,
  input  logic              in_pred_taken,
  input  logic [XLEN-1:0]   in_pred_target,
  input  logic [TAG_W-1:0]  rob_head,
  input  logic              flush_valid,
  input  logic [TAG_W-1:0]  flush_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_rob_tag,
  output logic [PREG_W-1:0] out_pd,
  output logic              out_wb_en,
  output logic [XLEN-1:0]   out_wb_data,
  output logic              out_taken,
  output logic [XLEN-1:0]   out_next_pc,
  output logic              out_mispredict,
  output logic              out_illegal
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [TAG_W-1:0]  rob_tag;
    logic [PREG_W-1:0] pd;
    logic              wb_en;
    logic [XLEN-1:0]   wb_data;
    logic              taken;
    logic [XLEN-1:0]   next_pc;
    logic              mispredict;
    logic              illegal;
  } result_t;

  result_t res_d;
  result_t res_q;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pred_next;
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            taken;
  logic            wb_en;
  logic            legal;

  logic            accept;
  logic            in_flush;
  logic            held_flush;
  logic            valid_d;
  logic            load;

  // Age relative to the ROB head; larger means younger.
  function automatic logic [TAG_W-1:0] age(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] head);
    return TAG_W'(t - head);
  endfunction

  assign pc_plus4    = in_pc + XLEN'(4);
  assign br_target   = in_pc + in_imm;
  assign jalr_target = (in_rs1 + in_imm) & ~XLEN'(1);

  assign eq   = (in_rs1 == in_rs2);
  assign lt_s = ($signed(in_rs1) < $signed(in_rs2));
  assign lt_u = (in_rs1 < in_rs2);

  // Opcode/func3 decode and branch resolution.
  always_comb begin
    taken  = 1'b0;
    wb_en  = 1'b0;
    legal  = 1'b1;
    target = br_target;
    case (in_opcode)
      OP_BRANCH: begin
        case (in_func3)
          F3_BEQ:  taken = eq;
          F3_BNE:  taken = !eq;
          F3_BLT:  taken = lt_s;
          F3_BGE:  taken = !lt_s;
          F3_BLTU: taken = lt_u;
          F3_BGEU: taken = !lt_u;
          default: legal = 1'b0;
        endcase
      end
      OP_JAL: begin
        taken = 1'b1;
        wb_en = 1'b1;
      end
      OP_JALR: begin
        if (in_func3 == 3'b000) begin
          taken  = 1'b1;
          wb_en  = 1'b1;
          target = jalr_target;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  assign next_pc   = taken ? target : pc_plus4;
  assign pred_next = in_pred_taken ? in_pred_target : pc_plus4;

  always_comb begin
    res_d            = '0;
    res_d.rob_tag    = in_rob_tag;
    res_d.pd         = in_pd;
    res_d.wb_en      = wb_en;
    res_d.wb_data    = pc_plus4;
    res_d.taken      = taken;
    res_d.next_pc    = next_pc;
    res_d.mispredict = legal && (next_pc != pred_next);
    res_d.illegal    = !legal;
  end

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign in_flush   = flush_valid &&
                      (age(in_rob_tag, rob_head) > age(flush_tag, rob_head));
  assign held_flush = flush_valid &&
                      (age(res_q.rob_tag, rob_head) > age(flush_tag, rob_head));

  // Result register control: a flushed issue completes its handshake but never loads.
  always_comb begin
    valid_d = out_valid;
    load    = 1'b0;
    if (accept) begin
      valid_d = !in_flush;
      load    = !in_flush;
    end else if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end else if (out_valid && held_flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else begin
      out_valid <= valid_d;
      if (load) begin
        res_q <= res_d;
      end
    end
  end

  assign out_rob_tag    = res_q.rob_tag;
  assign out_pd         = res_q.pd;
  assign out_wb_en      = res_q.wb_en;
  assign out_wb_data    = res_q.wb_data;
  assign out_taken      = res_q.taken;
  assign out_next_pc    = res_q.next_pc;
  assign out_mispredict = res_q.mispredict;
  assign out_illegal    = res_q.illegal;

endmodule

// File: tb/tb_fu_branch_pipe.sv
// Scoreboard bench for fu_branch_pipe: directed cases plus randomized traffic with
// backpressure and flushes, checked against a behavioural reference model.
module tb_fu_branch_pipe;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned PREG_W    = 7;

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_func3;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_rs1;
  logic [XLEN-1:0]   in_rs2;
  logic [PREG_W-1:0] in_pd;
  logic [TAG_W-1:0]  in_rob_tag;
  logic              in_pred_taken;
  logic [XLEN-1:0]   in_pred_target;
  logic [TAG_W-1:0]  rob_head;
  logic              flush_valid;
  logic [TAG_W-1:0]  flush_tag;
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_rob_tag;
  logic [PREG_W-1:0] out_pd;
  logic              out_wb_en;
  logic [XLEN-1:0]   out_wb_data;
  logic              out_taken;
  logic [XLEN-1:0]   out_next_pc;
  logic              out_mispredict;
  logic              out_illegal;

  fu_branch_pipe #(
    .XLEN(XLEN), .ROB_DEPTH(ROB_DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_func3(in_func3),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pd(in_pd),
    .in_rob_tag(in_rob_tag), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .rob_head(rob_head), .flush_valid(flush_valid), .flush_tag(flush_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_rob_tag(out_rob_tag), .out_pd(out_pd),
    .out_wb_en(out_wb_en), .out_wb_data(out_wb_data), .out_taken(out_taken),
    .out_next_pc(out_next_pc), .out_mispredict(out_mispredict), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [6:0]  pd;
    logic [3:0]  tag;
    bit          pred_taken;
    logic [31:0] pred_target;
    bit          out_ready;
    logic [3:0]  rob_head;
    bit          flush_valid;
    logic [3:0]  flush_tag;
  } stim_t;

  typedef struct {
    logic [3:0]  tag;
    logic [6:0]  pd;
    bit          wb_en;
    logic [31:0] wb_data;
    bit          taken;
    logic [31:0] next_pc;
    bit          mispredict;
    bit          illegal;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit younger(input logic [3:0] t, input logic [3:0] f, input logic [3:0] h);
    int at;
    int af;
    at = (int'(t) - int'(h) + 16) % 16;
    af = (int'(f) - int'(h) + 16) % 16;
    return at > af;
  endfunction

  // Reference: architectural RV32 branch/jump semantics.
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    logic [31:0] tgt;
    logic [31:0] pn;
    bit          ok;
    bit          tk;
    bit          wb;
    ok  = 1'b1;
    tk  = 1'b0;
    wb  = 1'b0;
    tgt = s.pc + s.imm;
    case (s.opcode)
      OP_BR: begin
        case (s.func3)
          3'd0: tk = (s.rs1 == s.rs2);
          3'd1: tk = (s.rs1 != s.rs2);
          3'd4: tk = ($signed(s.rs1) <  $signed(s.rs2));
          3'd5: tk = ($signed(s.rs1) >= $signed(s.rs2));
          3'd6: tk = (s.rs1 <  s.rs2);
          3'd7: tk = (s.rs1 >= s.rs2);
          default: ok = 1'b0;
        endcase
      end
      OP_JAL: begin
        tk = 1'b1;
        wb = 1'b1;
      end
      OP_JALR: begin
        if (s.func3 == 3'd0) begin
          tk  = 1'b1;
          wb  = 1'b1;
          tgt = (s.rs1 + s.imm) & 32'hFFFF_FFFE;
        end else begin
          ok = 1'b0;
        end
      end
      default: ok = 1'b0;
    endcase
    e.tag        = s.tag;
    e.pd         = s.pd;
    e.wb_en      = wb;
    e.wb_data    = s.pc + 32'd4;
    e.taken      = tk;
    e.next_pc    = tk ? tgt : s.pc + 32'd4;
    pn           = s.pred_taken ? s.pred_target : s.pc + 32'd4;
    e.mispredict = ok && (e.next_pc != pn);
    e.illegal    = !ok;
    return e;
  endfunction

  function automatic stim_t idle(input bit rdy);
    stim_t s;
    s = '{default: '0};
    s.out_ready = rdy;
    return s;
  endfunction

  function automatic stim_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [3:0] tag, input bit pt, input logic [31:0] ptgt);
    stim_t s;
    s = idle(1'b1);
    s.valid = 1'b1;
    s.opcode = op;
    s.func3 = f3;
    s.pc = pc;
    s.imm = imm;
    s.rs1 = rs1;
    s.rs2 = rs2;
    s.tag = tag;
    s.pd = 7'(tag) + 7'd40;
    s.pred_taken = pt;
    s.pred_target = ptgt;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t       s;
    int          r;
    logic [31:0] ir;
    exp_t        e;
    s = idle($urandom_range(0, 9) < 7);
    s.valid = ($urandom_range(0, 3) != 0);
    r = int'($urandom_range(0, 9));
    s.func3 = 3'($urandom);
    if (r <= 5)      s.opcode = OP_BR;
    else if (r == 6) s.opcode = OP_JAL;
    else if (r <= 8) s.opcode = OP_JALR;
    else             s.opcode = 7'($urandom);
    if (r == 7) s.func3 = 3'd0;
    s.pc  = $urandom & 32'hFFFF_FFFC;
    ir    = $urandom;
    s.imm = {{20{ir[11]}}, ir[11:0]};
    s.rs1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
    s.rs2 = ($urandom_range(0, 2) == 0) ? s.rs1 : $urandom;
    s.tag = 4'($urandom);
    s.pd  = 7'($urandom);
    s.pred_taken  = 1'($urandom);
    s.pred_target = $urandom;
    if ($urandom_range(0, 1) == 0) begin
      e = model(s);
      s.pred_taken  = e.taken;
      s.pred_target = e.next_pc;
    end
    s.rob_head    = 4'($urandom);
    s.flush_valid = ($urandom_range(0, 4) == 0);
    s.flush_tag   = 4'($urandom);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    in_valid       = s.valid;
    in_opcode      = s.opcode;
    in_func3       = s.func3;
    in_pc          = s.pc;
    in_imm         = s.imm;
    in_rs1         = s.rs1;
    in_rs2         = s.rs2;
    in_pd          = s.pd;
    in_rob_tag     = s.tag;
    in_pred_taken  = s.pred_taken;
    in_pred_target = s.pred_target;
    out_ready      = s.out_ready;
    rob_head       = s.rob_head;
    flush_valid    = s.flush_valid;
    flush_tag      = s.flush_tag;
  endtask

  // One clock of stimulus; the expected result is queued at the edge that accepts it.
  task automatic step(input stim_t s, output bit acc);
    bit   keep;
    exp_t e;
    drive(s);
    @(negedge clk);
    acc  = s.valid && in_ready;
    keep = acc && !(s.flush_valid && younger(s.tag, s.flush_tag, s.rob_head));
    e    = model(s);
    @(posedge clk);
    if (keep) exp_q.push_back(e);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("mon_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("mon_in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
        if (exp_q.size() != 0 && out_valid) begin
          chk("mon_rob_tag", 32'(out_rob_tag), 32'(exp_q[0].tag));
          chk("mon_pd", 32'(out_pd), 32'(exp_q[0].pd));
          chk("mon_wb_en", 32'(out_wb_en), 32'(exp_q[0].wb_en));
          chk("mon_wb_data", out_wb_data, exp_q[0].wb_data);
          chk("mon_taken", 32'(out_taken), 32'(exp_q[0].taken));
          chk("mon_next_pc", out_next_pc, exp_q[0].next_pc);
          chk("mon_mispredict", 32'(out_mispredict), 32'(exp_q[0].mispredict));
          chk("mon_illegal", 32'(out_illegal), 32'(exp_q[0].illegal));
        end
        if (exp_q.size() != 0) begin
          if (out_ready) void'(exp_q.pop_front());
          else if (flush_valid && younger(exp_q[0].tag, flush_tag, rob_head)) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    stim_t s;
    bit    acc;
    reset = 1'b0;
    drive(idle(1'b1));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_next_pc", out_next_pc, 32'd0);
    chk("rst_rob_tag", 32'(out_rob_tag), 32'd0);
    chk("rst_wb_en", 32'(out_wb_en), 32'd0);
    mon_en = 1'b1;

    // BNE taken, predicted not-taken
    step(mk(OP_BR, 3'b001, 32'h100, 32'h20, 32'd5, 32'd3, 4'd4, 1'b0, 32'd0), acc);
    chk("bne_acc", 32'(acc), 32'd1);
    chk("bne_valid", 32'(out_valid), 32'd1);
    chk("bne_taken", 32'(out_taken), 32'd1);
    chk("bne_next_pc", out_next_pc, 32'h120);
    chk("bne_mispredict", 32'(out_mispredict), 32'd1);
    chk("bne_wb_en", 32'(out_wb_en), 32'd0);
    chk("bne_rob_tag", 32'(out_rob_tag), 32'd4);

    // Signed vs unsigned compare on the same operands
    step(mk(OP_BR, 3'b100, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 4'd5, 1'b0, 32'd0), acc);
    chk("blt_taken", 32'(out_taken), 32'd1);
    step(mk(OP_BR, 3'b110, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 4'd5, 1'b0, 32'd0), acc);
    chk("bltu_taken", 32'(out_taken), 32'd0);
    chk("bltu_next_pc", out_next_pc, 32'h304);
    chk("bltu_mispredict", 32'(out_mispredict), 32'd0);

    // JALR target low bit cleared, correct and wrong prediction
    step(mk(OP_JALR, 3'b000, 32'h200, 32'd4, 32'h1001, 32'd0, 4'd6, 1'b1, 32'h1004), acc);
    chk("jalr_next_pc", out_next_pc, 32'h1004);
    chk("jalr_wb_data", out_wb_data, 32'h204);
    chk("jalr_wb_en", 32'(out_wb_en), 32'd1);
    chk("jalr_mispredict", 32'(out_mispredict), 32'd0);
    step(mk(OP_JALR, 3'b000, 32'h200, 32'd4, 32'h1001, 32'd0, 4'd6, 1'b1, 32'h1000), acc);
    chk("jalr_bad_pred", 32'(out_mispredict), 32'd1);

    // Reserved branch func3
    step(mk(OP_BR, 3'b010, 32'h400, 32'h10, 32'd1, 32'd1, 4'd2, 1'b1, 32'h999), acc);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_mispredict", 32'(out_mispredict), 32'd0);
    chk("ill_next_pc", out_next_pc, 32'h404);
    step(idle(1'b1), acc);

    // Backpressure: three back-to-back issues while the consumer stalls
    s = mk(OP_JAL, 3'b000, 32'h500, 32'h80, 32'd0, 32'd0, 4'd7, 1'b1, 32'h580);
    s.out_ready = 1'b0;
    step(s, acc);
    chk("bp_a_acc", 32'(acc), 32'd1);
    s = mk(OP_BR, 3'b000, 32'h600, 32'h8, 32'd9, 32'd9, 4'd8, 1'b0, 32'd0);
    s.out_ready = 1'b0;
    step(s, acc);
    chk("bp_b_stall1", 32'(acc), 32'd0);
    chk("bp_hold_tag1", 32'(out_rob_tag), 32'd7);
    step(s, acc);
    chk("bp_b_stall2", 32'(acc), 32'd0);
    chk("bp_hold_pc", out_next_pc, 32'h580);
    s.out_ready = 1'b1;
    step(s, acc);
    chk("bp_b_acc", 32'(acc), 32'd1);
    chk("bp_b_tag", 32'(out_rob_tag), 32'd8);
    step(mk(OP_BR, 3'b111, 32'h700, 32'h8, 32'd1, 32'd2, 4'd9, 1'b0, 32'd0), acc);
    chk("bp_c_acc", 32'(acc), 32'd1);
    chk("bp_c_tag", 32'(out_rob_tag), 32'd9);
    step(idle(1'b1), acc);

    // Flush around rob_head=14, flush_tag=15
    s = mk(OP_BR, 3'b001, 32'h800, 32'h10, 32'd1, 32'd2, 4'd1, 1'b0, 32'd0);
    s.out_ready = 1'b0;
    s.rob_head = 4'd14;
    step(s, acc);
    s = idle(1'b0);
    s.rob_head = 4'd14;
    s.flush_valid = 1'b1;
    s.flush_tag = 4'd15;
    step(s, acc);
    chk("flush_young_drop", 32'(out_valid), 32'd0);
    s = mk(OP_BR, 3'b001, 32'h900, 32'h10, 32'd1, 32'd2, 4'd15, 1'b0, 32'd0);
    s.out_ready = 1'b0;
    s.rob_head = 4'd14;
    step(s, acc);
    s = idle(1'b0);
    s.rob_head = 4'd14;
    s.flush_valid = 1'b1;
    s.flush_tag = 4'd15;
    step(s, acc);
    chk("flush_equal_keep", 32'(out_valid), 32'd1);
    chk("flush_equal_tag", 32'(out_rob_tag), 32'd15);
    step(idle(1'b1), acc);
    s = mk(OP_JAL, 3'b000, 32'hA00, 32'h10, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    s.rob_head = 4'd14;
    s.flush_valid = 1'b1;
    s.flush_tag = 4'd15;
    step(s, acc);
    chk("flush_issue_acc", 32'(acc), 32'd1);
    chk("flush_issue_hidden", 32'(out_valid), 32'd0);
    step(idle(1'b1), acc);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(rand_stim(), acc);
    end
    step(idle(1'b1), acc);
    step(idle(1'b1), acc);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while a result is held
    mon_en = 1'b0;
    s = mk(OP_JAL, 3'b000, 32'hB00, 32'h10, 32'd0, 32'd0, 4'd3, 1'b0, 32'd0);
    s.out_ready = 1'b0;
    step(s, acc);
    chk("arst_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    #5;
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_branch_pipe.md
Name: fu_branch_pipe

Overview:
Parametrised, registered branch/jump execution unit; successor to the single-cycle bne/jalr unit. Resolves all RV32 conditional branches plus JAL/JALR and computes the link value. Compares the actual next PC against the predicted next PC and reports a mispredict to the ROB. Sits between the branch RS/PRF read stage and the ROB/CDB, with a valid/ready handshake on both sides and age-based flush of in-flight work.

Parameters:
XLEN, 32, data/PC width
ROB_DEPTH, 16, ROB entries (power of 2)
TAG_W, $clog2(ROB_DEPTH), ROB tag width
PREG_W, 7, physical register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  issue request from RS
in_ready  out  1  unit can accept this cycle
in_opcode  in  7  instruction opcode
in_func3  in  3  instruction func3
in_pc  in  XLEN  instruction PC
in_imm  in  XLEN  sign-extended immediate
in_rs1  in  XLEN  ps1 data from PRF
in_rs2  in  XLEN  ps2 data from PRF
in_pd  in  PREG_W  destination physical register
in_rob_tag  in  TAG_W  ROB index
in_pred_taken  in  1  frontend predicted taken
in_pred_target  in  XLEN  frontend predicted target
rob_head  in  TAG_W  oldest ROB tag (age reference)
flush_valid  in  1  partial flush broadcast
flush_tag  in  TAG_W  flush all entries younger than this tag
out_valid  out  1  result held
out_ready  in  1  ROB/CDB accepts result
out_rob_tag  out  TAG_W  result ROB index
out_pd  out  PREG_W  result destination
out_wb_en  out  1  write out_wb_data to out_pd (JAL/JALR only)
out_wb_data  out  XLEN  link value pc+4
out_taken  out  1  resolved direction
out_next_pc  out  XLEN  actual next PC
out_mispredict  out  1  actual next PC != predicted next PC
out_illegal  out  1  unsupported opcode/func3

Behaviour:
- Reset (reset low, async): out_valid=0; all other out_* registers 0. in_ready follows its equation (1 after reset).
- One result register. in_ready = !out_valid || out_ready. Accept when in_valid && in_ready. Result visible on out_* from the cycle after accept (latency 1). Result holds stable while out_valid && !out_ready.
- Back-to-back: accept and drain in the same cycle gives a new result the next cycle, one per cycle throughput.
- Decode:
  - opcode 1100011 with func3 000 BEQ, 001 BNE, 100 BLT, 101 BGE (signed), 110 BLTU, 111 BGEU (unsigned). target = pc+imm. wb_en=0.
  - 1101111 JAL: taken=1, target=pc+imm, wb_en=1.
  - 1100111 with func3 000 JALR: taken=1, target=(rs1+imm)&~1, wb_en=1.
  - Anything else, including branch func3 010/011: illegal=1, taken=0, mispredict=0, wb_en=0, next_pc=pc+4.
- wb_data = pc+4. next_pc = taken ? target : pc+4. pred_next = pred_taken ? pred_target : pc+4. mispredict = (next_pc != pred_next). All arithmetic is modulo 2^XLEN.
- Age: age(t) = (t - rob_head) mod ROB_DEPTH. An entry is younger than the flush tag when age(t) > age(flush_tag). The entry equal to flush_tag survives.
- Flush (flush_valid=1):
  - A held result younger than the flush tag is dropped: out_valid=0 next cycle, even if out_ready is 0.
  - A same-cycle issue younger than the flush tag is accepted (handshake completes) but discarded, so it is never visible.
  - Older/equal entries are unaffected.
- Simultaneous drain and flush of the held entry: drain wins for that cycle's handshake. The consumer ignores the transfer per its own flush rule.
- Reset asserted mid-operation clears out_valid immediately, asynchronously.

Test Plan:
- BNE rs1=5, rs2=3, pc=0x100, imm=0x20, pred_taken=0, tag=4 -> next cycle out_valid=1, taken=1, next_pc=0x120, mispredict=1, wb_en=0, rob_tag=4.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1. Same operands as BLTU -> taken=0, next_pc=pc+4, mispredict=0 with pred_taken=0.
- JALR pc=0x200, rs1=0x1001, imm=4, pred_target=0x1004, pred_taken=1 -> next_pc=0x1004, wb_data=0x204, wb_en=1, mispredict=0. With pred_target=0x1000 -> mispredict=1.
- Backpressure: issue 3 back-to-back with out_ready=0 for 2 cycles -> in_ready=0 while held, result stable, no loss. Order preserved when out_ready=1.
- Flush with rob_head=14, held tag=1, flush_tag=15 -> held result dropped. Held tag=15 kept. Same-cycle issue tag=0 accepted and never appears on out_*.
- opcode 1100011 func3 010 -> out_illegal=1, mispredict=0. Assert reset while out_valid=1 -> out_valid=0 immediately.
